// File: rtl/y_skip_add_if.sv
// Bundle between the skip-add stage, the xD/SSM producers and the consumer.
//
// Handshake: the producer holds start high with y_ssm_flat/xD_flat stable
// until xd_ack pulses (one cycle). done stays high while y_flat is
// complete. The consumer takes y_flat by raising out_ack, which is only
// honoured while done is high. state_dbg mirrors the control FSM state.
interface y_skip_add_if #(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int DW = 16
);
    localparam int NE = B * H * P;

    logic             start;
    logic             out_ack;
    logic [NE*DW-1:0] y_ssm_flat;
    logic [NE*DW-1:0] xD_flat;
    logic [NE*DW-1:0] y_flat;
    logic             xd_ack;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, out_ack, y_ssm_flat, xD_flat,
        input  y_flat, xd_ack, done, state_dbg
    );

    modport slave (
        input  start, out_ack, y_ssm_flat, xD_flat,
        output y_flat, xd_ack, done, state_dbg
    );
endinterface

// File: rtl/y_skip_add.sv
// Output stage of the SSM datapath: y = y_ssm + xD, element-wise FP16.
// PAR_H adder lanes walk heads in parallel; each result carries its element
// index through a tag pipe aligned with the adder latency.

// Pipelined FP16 adder, round-to-nearest-even; valid_in to valid_out = A_LAT.
module fp16_add_wrapper #(
    parameter int A_LAT = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    logic [15:0] r_pipe [A_LAT];
    logic        v_pipe [A_LAT];

    // Exact alignment in a 42-bit field (exponent span fits), single rounding.
    function automatic logic [15:0] fp16_add(input logic [15:0] a_in, input logic [15:0] b_in);
        logic [15:0] x, y;
        logic [4:0]  ex, ey;
        logic [41:0] mx, my, s, mask;
        logic [16:0] q, field;
        logic        guard, sticky;
        int          l, e_res, sh;
        if (a_in[14:10] == 5'h1f || b_in[14:10] == 5'h1f) begin
            if ((a_in[14:10] == 5'h1f && a_in[9:0] != 10'd0) ||
                (b_in[14:10] == 5'h1f && b_in[9:0] != 10'd0)) return 16'h7e00;
            if (a_in[14:10] == 5'h1f && b_in[14:10] == 5'h1f && a_in[15] != b_in[15]) return 16'h7e00;
            return (a_in[14:10] == 5'h1f) ? a_in : b_in;
        end
        if (b_in[14:0] > a_in[14:0]) begin
            x = b_in; y = a_in;
        end else begin
            x = a_in; y = b_in;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx = {1'b0, (x[14:10] != 5'd0), x[9:0], 30'd0};
        my = {1'b0, (y[14:10] != 5'd0), y[9:0], 30'd0} >> (ex - ey);
        s  = (x[15] == y[15]) ? (mx + my) : (mx - my);
        if (s == 42'd0) return {(x[15] & y[15]), 15'd0};
        l = 0;
        for (int k = 0; k < 42; k++) if (s[k]) l = k;
        e_res  = int'(ex) + l - 40;
        sh     = (e_res >= 1) ? (l - 10) : (31 - int'(ex));
        q      = 17'(s >> sh);
        guard  = s[6'(sh - 1)];
        mask   = (42'd1 << (sh - 1)) - 42'd1;
        sticky = |(s & mask);
        if (guard && (sticky || q[0])) q = q + 17'd1;
        // q carries the implicit one, so a rounding carry bumps the exponent.
        field = ((e_res >= 1) ? (17'(e_res - 1) << 10) : 17'd0) + q;
        if (field >= 17'h7c00) field = 17'h7c00;
        return {x[15], field[14:0]};
    endfunction

    // Result and valid delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < A_LAT; s++) begin
                r_pipe[s] <= '0;
                v_pipe[s] <= 1'b0;
            end
        end else begin
            v_pipe[0] <= valid_in;
            if (valid_in) r_pipe[0] <= fp16_add(a, b);
            for (int s = 1; s < A_LAT; s++) begin
                v_pipe[s] <= v_pipe[s-1];
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign valid_out = v_pipe[A_LAT-1];
    assign result    = r_pipe[A_LAT-1];
endmodule

module y_skip_add #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int DW    = 16,
    parameter int A_LAT = 11,
    parameter int PAR_H = 12
) (
    input  logic clk,
    input  logic rst,
    y_skip_add_if.slave bus
);
    localparam int NE = B * H * P;
    localparam int GW = (NE > 1) ? $clog2(NE) : 1;
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int HW = $clog2(H + PAR_H + 1);
    localparam int CW = $clog2(A_LAT + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   bi;
    logic [HW-1:0]   hi;
    logic [PW-1:0]   pi;
    logic [CW-1:0]   fcnt;
    logic            last_idx;
    logic            xd_ack_q, done_q;
    logic [DW-1:0]   op_a  [PAR_H];
    logic [DW-1:0]   op_b  [PAR_H];
    logic            op_v  [PAR_H];
    logic [GW-1:0]   tag   [PAR_H][A_LAT+1];
    logic [DW-1:0]   res   [PAR_H];
    logic            res_v [PAR_H];
    logic [DW-1:0]   y_mem [NE];

    function automatic int lane_idx(input int i);
        return int'(bi) * H * P + (int'(hi) + i) * P + int'(pi);
    endfunction

    assign last_idx = (int'(pi) == P - 1) && (int'(hi) + PAR_H >= H) && (int'(bi) == B - 1);

    // Next-state decode; start only matters in IDLE, out_ack only in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_CALC;
            S_CALC:  if (last_idx) state_nx = S_FLUSH;
            S_FLUSH: if (int'(fcnt) == A_LAT + 2) state_nx = S_DONE;
            S_DONE:  if (bus.out_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, index walk (p fastest, then h by PAR_H, then b) and flush counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            bi       <= '0;
            hi       <= '0;
            pi       <= '0;
            fcnt     <= '0;
            xd_ack_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            xd_ack_q <= (state == S_CALC) && last_idx;
            done_q   <= (state_nx == S_DONE);
            if (state == S_IDLE && bus.start) begin
                bi   <= '0;
                hi   <= '0;
                pi   <= '0;
                fcnt <= '0;
            end else if (state == S_CALC) begin
                fcnt <= '0;
                if (int'(pi) == P - 1) begin
                    pi <= '0;
                    if (int'(hi) + PAR_H >= H) begin
                        hi <= '0;
                        bi <= bi + BW'(1);
                    end else begin
                        hi <= hi + HW'(PAR_H);
                    end
                end else begin
                    pi <= pi + PW'(1);
                end
            end else if (state == S_FLUSH) begin
                fcnt <= fcnt + CW'(1);
            end
        end
    end

    // Operand capture per lane; lanes past the last head stay idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PAR_H; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
                op_v[i] <= 1'b0;
                for (int s = 0; s <= A_LAT; s++) tag[i][s] <= '0;
            end
        end else begin
            for (int i = 0; i < PAR_H; i++) begin
                op_v[i] <= (state == S_CALC) && (int'(hi) + i < H);
                if (state == S_CALC && (int'(hi) + i < H)) begin
                    op_a[i]   <= bus.y_ssm_flat[lane_idx(i)*DW +: DW];
                    op_b[i]   <= bus.xD_flat[lane_idx(i)*DW +: DW];
                    tag[i][0] <= GW'(lane_idx(i));
                end
                for (int s = 1; s <= A_LAT; s++) tag[i][s] <= tag[i][s-1];
            end
        end
    end

    for (genvar i = 0; i < PAR_H; i++) begin : g_lane
        fp16_add_wrapper #(.A_LAT(A_LAT)) u_add (
            .clk       (clk),
            .rst_n     (rst),
            .valid_in  (op_v[i]),
            .a         (op_a[i]),
            .b         (op_b[i]),
            .valid_out (res_v[i]),
            .result    (res[i])
        );
    end

    // Write-back: each valid result lands only on its tagged element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < NE; g++) y_mem[g] <= '0;
        end else if (state == S_CALC || state == S_FLUSH) begin
            for (int i = 0; i < PAR_H; i++)
                if (res_v[i]) y_mem[tag[i][A_LAT]] <= res[i];
        end
    end

    for (genvar g = 0; g < NE; g++) begin : g_pack
        assign bus.y_flat[g*DW +: DW] = y_mem[g];
    end

    assign bus.xd_ack    = xd_ack_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_y_skip_add.sv
// Bench for y_skip_add: default geometry (H=4) plus an H=16 instance with a
// partial second pass of lanes.
`timescale 1ns/1ps
module tb_y_skip_add;
  localparam int A_LAT = 11;
  localparam int PAR_H = 12;
  localparam int P     = 4;
  localparam int H0    = 4;
  localparam int H1    = 16;
  localparam int NE0   = H0 * P;
  localparam int NE1   = H1 * P;
  localparam int N0    = 4;   // P * ceil(H0/PAR_H)
  localparam int N1    = 8;   // P * ceil(H1/PAR_H)

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  y_skip_add_if #(.B(1), .H(H0), .P(P), .DW(16)) bus0 ();
  y_skip_add_if #(.B(1), .H(H1), .P(P), .DW(16)) bus1 ();

  y_skip_add #(.B(1), .H(H0), .P(P), .DW(16), .A_LAT(A_LAT), .PAR_H(PAR_H))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  y_skip_add #(.B(1), .H(H1), .P(P), .DW(16), .A_LAT(A_LAT), .PAR_H(PAR_H))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real fp16_to_real(input logic [15:0] h);
    real m;
    int  sc;
    if (h[14:10] == 5'd0) begin
      m = real'(h[9:0]);
      sc = -24;
    end else begin
      m = 1024.0 + real'(h[9:0]);
      sc = int'(h[14:10]) - 25;
    end
    while (sc > 0) begin m = m * 2.0; sc--; end
    while (sc < 0) begin m = m / 2.0; sc++; end
    return h[15] ? -m : m;
  endfunction

  function automatic int rne(input real r);
    int f;
    f = $rtoi(r);
    if ((r - real'(f) > 0.5) || ((r - real'(f) == 0.5) && (f % 2 == 1))) f++;
    return f;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real v);
    logic s;
    real  a, r;
    int   e, f;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a == 0.0) return {s, 15'd0};
    if (a < 6.103515625e-05) begin
      f = rne(a * 16777216.0);
      return {s, 15'(f)};
    end
    e = 0;
    r = a;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    f = rne((r - 1.0) * 1024.0);
    if (f == 1024) begin f = 0; e++; end
    if (e > 15) return {s, 15'h7c00};
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    real sum;
    sum = fp16_to_real(a) + fp16_to_real(b);
    if (sum == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    return real_to_fp16(sum);
  endfunction

  function automatic logic [15:0] rand_fp16();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic logic [NE1*16-1:0] bcast(input logic [15:0] v);
    logic [NE1*16-1:0] r;
    for (int g = 0; g < NE1; g++) r[g*16 +: 16] = v;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int sel, input logic v);
    if (sel == 1) bus1.start = v; else bus0.start = v;
  endtask

  // One full run: expected y elements must already be in exp_q.
  task automatic run(input int sel, input logic [NE1*16-1:0] ys, input logic [NE1*16-1:0] xs,
                     input bit poke, input string tagname);
    int ne, n, k, acks, ack_at, done_at;
    logic xd, dn;
    logic [NE1*16-1:0] yv;
    logic [15:0] e;
    ne = (sel == 1) ? NE1 : NE0;
    n  = (sel == 1) ? N1 : N0;
    @(negedge clk);
    if (sel == 1) begin
      bus1.y_ssm_flat = ys;
      bus1.xD_flat    = xs;
    end else begin
      bus0.y_ssm_flat = ys[NE0*16-1:0];
      bus0.xD_flat    = xs[NE0*16-1:0];
    end
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    k = 0; acks = 0; ack_at = -1; done_at = -1;
    while (done_at < 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (poke && k == 2) set_start(sel, 1'b1);
      if (poke && k == 3) set_start(sel, 1'b0);
      xd = (sel == 1) ? bus1.xd_ack : bus0.xd_ack;
      dn = (sel == 1) ? bus1.done : bus0.done;
      if (xd) begin
        acks++;
        if (ack_at < 0) ack_at = k;
      end
      if (dn) done_at = k;
    end
    check({tagname, " xd_ack_count"}, acks, 1);
    check({tagname, " xd_ack_edge"}, ack_at, n);
    check({tagname, " done_edge"}, done_at, n + A_LAT + 3);
    yv = (sel == 1) ? bus1.y_flat : {{(NE1-NE0)*16{1'b0}}, bus0.y_flat};
    for (int g = 0; g < ne; g++) begin
      if (exp_q.size() == 0) begin
        check({tagname, " scoreboard_empty"}, 1, 0);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("%s y[%0d]", tagname, g), yv[g*16 +: 16], e);
    end
  endtask

  task automatic ack(input int sel, input bit with_start);
    int bad;
    @(negedge clk);
    if (sel == 1) bus1.out_ack = 1'b1; else bus0.out_ack = 1'b1;
    set_start(sel, with_start);
    @(posedge clk);
    #1;
    bus0.out_ack = 1'b0;
    bus1.out_ack = 1'b0;
    set_start(sel, 1'b0);
    check("done_after_ack", (sel == 1) ? bus1.done : bus0.done, 0);
    if (with_start) begin
      bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus0.done || bus0.xd_ack) bad++;
      end
      check("no_run_after_ack_with_start", bad, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[10];
  initial begin
    int bad;
    logic [NE1*16-1:0] ys, xs;

    tbl[0] = '{16'h3C00, 16'h4000, 16'h4200};
    tbl[1] = '{16'h3C00, 16'hBC00, 16'h0000};
    tbl[2] = '{16'h3800, 16'h3800, 16'h3C00};
    tbl[3] = '{16'hC200, 16'h3C00, 16'hC000};
    tbl[4] = '{16'h7BFF, 16'h7BFF, 16'h7C00};
    tbl[5] = '{16'h0001, 16'h0001, 16'h0002};
    tbl[6] = '{16'h03FF, 16'h0001, 16'h0400};
    tbl[7] = '{16'h3C00, 16'h1000, 16'h3C00};
    tbl[8] = '{16'h3C01, 16'h1000, 16'h3C02};
    tbl[9] = '{16'h7BFF, 16'h3C00, 16'h7BFF};

    // Reset with random inputs.
    rst = 1'b0;
    bus0.start = 1'b0; bus0.out_ack = 1'b0;
    bus1.start = 1'b0; bus1.out_ack = 1'b0;
    for (int g = 0; g < NE1; g++) begin
      ys[g*16 +: 16] = rand_fp16();
      xs[g*16 +: 16] = rand_fp16();
    end
    bus0.y_ssm_flat = ys[NE0*16-1:0]; bus0.xD_flat = xs[NE0*16-1:0];
    bus1.y_ssm_flat = ys;             bus1.xD_flat = xs;
    repeat (3) @(negedge clk);
    check("reset_y0_zero", bus0.y_flat == '0, 1);
    check("reset_y1_zero", bus1.y_flat == '0, 1);
    check("reset_done", {bus0.done, bus1.done}, 0);
    check("reset_xd_ack", {bus0.xd_ack, bus1.xd_ack}, 0);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.done || bus0.xd_ack || bus0.y_flat != '0 || bus1.done || bus1.xd_ack || bus1.y_flat != '0) bad++;
    end
    check("idle_outputs_stable", bad, 0);

    // Table-driven broadcast vectors on the default geometry.
    for (int r = 0; r < 10; r++) begin
      for (int g = 0; g < NE0; g++) exp_q.push_back(tbl[r].y);
      run(0, bcast(tbl[r].a), bcast(tbl[r].b), (r == 1), $sformatf("tbl%0d", r));
      if (r == 0) begin
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (!bus0.done) bad++;
          for (int g = 0; g < NE0; g++) if (bus0.y_flat[g*16 +: 16] !== tbl[r].y) bad++;
        end
        check("done_hold_50", bad, 0);
      end
      ack(0, (r == 2));
    end

    // Index mapping: y = xD[g] = g.
    for (int g = 0; g < NE1; g++) xs[g*16 +: 16] = real_to_fp16(real'(g));
    for (int g = 0; g < NE0; g++) exp_q.push_back(xs[g*16 +: 16]);
    run(0, '0, xs, 1'b0, "map_h4");
    ack(0, 1'b0);
    for (int g = 0; g < NE1; g++) exp_q.push_back(xs[g*16 +: 16]);
    run(1, '0, xs, 1'b0, "map_h16");
    ack(1, 1'b0);

    // Random operands against the model.
    for (int t = 0; t < 7; t++) begin
      int sel;
      sel = (t >= 5) ? 1 : 0;
      for (int g = 0; g < NE1; g++) begin
        ys[g*16 +: 16] = rand_fp16();
        xs[g*16 +: 16] = rand_fp16();
      end
      for (int g = 0; g < ((sel == 1) ? NE1 : NE0); g++)
        exp_q.push_back(ref_add(ys[g*16 +: 16], xs[g*16 +: 16]));
      run(sel, ys, xs, 1'b0, $sformatf("rand%0d", t));
      ack(sel, 1'b0);
    end

    // Reset in the third FLUSH cycle, then a clean restart.
    @(negedge clk);
    bus0.y_ssm_flat = bcast(16'h3C00);
    bus0.xD_flat    = bcast(16'h4000);
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    repeat (N0 + 2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_done", bus0.done, 0);
    check("midrst_y_zero", bus0.y_flat == '0, 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus0.done || bus0.xd_ack || bus0.y_flat != '0) bad++;
    end
    check("midrst_no_late_writes", bad, 0);
    for (int g = 0; g < NE0; g++) exp_q.push_back(16'h4200);
    run(0, bcast(16'h3C00), bcast(16'h4000), 1'b0, "restart");
    ack(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
